video_timing_gen: RTL

Parametrised raster timing generator: the successor to the fixed 9-bit arcade sync counter. It produces horizontal and vertical counters, blanking, sync, data-enable and frame/line strobes for one video channel. Every boundary is a parameter. It advances only on a pixel clock-enable. Screen-centering offsets are latched once per frame. It sits between the core's clock-enable divider and the video mixer/scandoubler.

---
 rtl/video_timing_pkg.sv | 25 ++
 rtl/video_timing_gen_if.sv | 33 +++
 rtl/video_window_cmp.sv | 11 +
 rtl/video_timing_gen.sv | 131 +++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Timing constants per supported core and width helper for the raster generator.
// No logic here; consumed at elaboration only.
package video_timing_pkg;

    // Arcade core (the original fixed 9-bit sync counter timing)
    localparam int ARC_HW           = 9;
    localparam int ARC_VW           = 9;
    localparam int ARC_H_ACT_END    = 256;
    localparam int ARC_H_SYNC_START = 274;
    localparam int ARC_H_SYNC_END   = 299;
    localparam int ARC_H_TOTAL      = 443;
    localparam int ARC_V_ACT_START  = 16;
    localparam int ARC_V_ACT_END    = 240;
    localparam int ARC_V_SYNC_START = 242;
    localparam int ARC_V_SYNC_END   = 245;
    localparam int ARC_V_TOTAL      = 263;
    localparam int ARC_HOFFS_W      = 5;
    localparam int ARC_VOFFS_W      = 3;

    // Line/frame length arithmetic needs one bit above the wider counter
    function automatic int lf_width(input int hw, input int vw);
        return ((hw > vw) ? hw : vw) + 1;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing bus between pixel-enable source, generator and video consumers.
// master = generator side; slave = the side driving enables/offsets and reading timing.
interface video_timing_gen_if
    import video_timing_pkg::*;
#(
    parameter int HW      = ARC_HW,
    parameter int VW      = ARC_VW,
    parameter int HOFFS_W = ARC_HOFFS_W,
    parameter int VOFFS_W = ARC_VOFFS_W
);
    logic               ce_pix;
    logic [HOFFS_W-1:0] hoffs;
    logic [VOFFS_W-1:0] voffs;
    logic [HW-1:0]      hcount;
    logic [VW-1:0]      vcount;
    logic               hb;
    logic               vb;
    logic               hs;
    logic               vs;
    logic               de;
    logic               line;
    logic               frame;

    modport master (
        input  ce_pix, hoffs, voffs,
        output hcount, vcount, hb, vb, hs, vs, de, line, frame
    );

    modport slave (
        output ce_pix, hoffs, voffs,
        input  hcount, vcount, hb, vb, hs, vs, de, line, frame
    );
endinterface

// File: rtl/video_window_cmp.sv
// Unsigned half-open window test: start <= cnt < end. Combinational, no backpressure.
module video_window_cmp #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_cnt,
    input  logic [W-1:0] i_start,
    input  logic [W-1:0] i_end,
    output logic         o_in_win
);
    assign o_in_win = (i_cnt >= i_start) && (i_cnt < i_end);
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, blank/sync/de and line/frame strobes.
// One clk from a ce_pix edge to all outputs; no backpressure, advances only on ce_pix.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int HW           = ARC_HW,
    parameter int VW           = ARC_VW,
    parameter int H_ACT_END    = ARC_H_ACT_END,
    parameter int H_SYNC_START = ARC_H_SYNC_START,
    parameter int H_SYNC_END   = ARC_H_SYNC_END,
    parameter int H_TOTAL      = ARC_H_TOTAL,
    parameter int V_ACT_START  = ARC_V_ACT_START,
    parameter int V_ACT_END    = ARC_V_ACT_END,
    parameter int V_SYNC_START = ARC_V_SYNC_START,
    parameter int V_SYNC_END   = ARC_V_SYNC_END,
    parameter int V_TOTAL      = ARC_V_TOTAL,
    parameter int HOFFS_W      = ARC_HOFFS_W,
    parameter int VOFFS_W      = ARC_VOFFS_W,
    parameter bit SYNC_POL     = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    video_timing_gen_if.master vif
);
    localparam int CW = lf_width(HW, VW);

    if (!(H_TOTAL - ((1 << HOFFS_W) - 1) > H_SYNC_END)) begin : g_err_hoffs
        $error("shortest line would truncate hsync");
    end
    if (!(V_TOTAL + (1 << VOFFS_W) - 1 <= (1 << VW))) begin : g_err_voffs
        $error("longest frame overflows vcount");
    end
    if (!(H_TOTAL <= (1 << HW))) begin : g_err_htotal
        $error("H_TOTAL overflows hcount");
    end
    if (!(H_ACT_END <= H_SYNC_START && H_SYNC_START < H_SYNC_END)) begin : g_err_horder
        $error("horizontal boundaries out of order");
    end
    if (!(V_ACT_START < V_ACT_END && V_ACT_END <= V_SYNC_START &&
          V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL)) begin : g_err_vorder
        $error("vertical boundaries out of order");
    end

    logic [HW-1:0]      r_hcount;
    logic [VW-1:0]      r_vcount;
    logic [HOFFS_W-1:0] r_hoffs_q;
    logic [VOFFS_W-1:0] r_voffs_q;
    logic               r_hb, r_vb, r_hs, r_vs, r_de, r_line, r_frame;

    logic [CW-1:0] w_line_len;
    logic [CW-1:0] w_frame_len;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_fwrap;
    logic [HW-1:0] w_hcount_nxt;
    logic [VW-1:0] w_vcount_nxt;
    logic          w_h_act, w_v_act, w_hs_win, w_vs_win;

    assign w_line_len  = CW'(H_TOTAL) - CW'(r_hoffs_q);
    assign w_frame_len = CW'(V_TOTAL) + CW'(r_voffs_q);
    assign w_h_last    = (CW'(r_hcount) == (w_line_len - CW'(1)));
    assign w_v_last    = (CW'(r_vcount) == (w_frame_len - CW'(1)));
    assign w_fwrap     = w_h_last & w_v_last;

    assign w_hcount_nxt = w_h_last ? '0 : r_hcount + HW'(1);
    assign w_vcount_nxt = !w_h_last ? r_vcount :
                          (w_v_last ? '0 : r_vcount + VW'(1));

    // Decode the post-update counters so outputs line up with the counts they accompany
    video_window_cmp #(.W(HW)) u_h_act (
        .i_cnt(w_hcount_nxt), .i_start('0),
        .i_end(HW'(H_ACT_END)), .o_in_win(w_h_act)
    );
    video_window_cmp #(.W(VW)) u_v_act (
        .i_cnt(w_vcount_nxt), .i_start(VW'(V_ACT_START)),
        .i_end(VW'(V_ACT_END)), .o_in_win(w_v_act)
    );
    video_window_cmp #(.W(HW)) u_h_sync (
        .i_cnt(w_hcount_nxt), .i_start(HW'(H_SYNC_START)),
        .i_end(HW'(H_SYNC_END)), .o_in_win(w_hs_win)
    );
    video_window_cmp #(.W(VW)) u_v_sync (
        .i_cnt(w_vcount_nxt), .i_start(VW'(V_SYNC_START)),
        .i_end(VW'(V_SYNC_END)), .o_in_win(w_vs_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount  <= '0;
            r_vcount  <= '0;
            r_hoffs_q <= '0;
            r_voffs_q <= '0;
            r_hb      <= 1'b1;
            r_vb      <= 1'b1;
            r_de      <= 1'b0;
            r_hs      <= ~SYNC_POL;
            r_vs      <= ~SYNC_POL;
            r_line    <= 1'b0;
            r_frame   <= 1'b0;
        end else if (vif.ce_pix) begin
            r_hcount <= w_hcount_nxt;
            r_vcount <= w_vcount_nxt;
            // Offsets only move at the frame seam so a frame never mixes line lengths
            if (w_fwrap) begin
                r_hoffs_q <= vif.hoffs;
                r_voffs_q <= vif.voffs;
            end
            r_hb    <= ~w_h_act;
            r_vb    <= ~w_v_act;
            r_de    <= w_h_act & w_v_act;
            r_hs    <= SYNC_POL ? w_hs_win : ~w_hs_win;
            r_vs    <= SYNC_POL ? w_vs_win : ~w_vs_win;
            r_line  <= w_h_last;
            r_frame <= w_fwrap;
        end else begin
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end
    end

    assign vif.hcount = r_hcount;
    assign vif.vcount = r_vcount;
    assign vif.hb     = r_hb;
    assign vif.vb     = r_vb;
    assign vif.hs     = r_hs;
    assign vif.vs     = r_vs;
    assign vif.de     = r_de;
    assign vif.line   = r_line;
    assign vif.frame  = r_frame;

endmodule
